// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte FIFO plus launch sequencer in front of async_transmitter. Bus-side
//   writers push bytes at any time. The sequencer pops one byte at a time,
//   gives the transmitter a one-cycle TxD_start pulse, then paces the next
//   launch on TxD_busy. If TxD_busy never rises, a timeout returns the
//   sequencer to IDLE so it cannot deadlock.
//
// Ports
//   clk_50mhz  in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   wr_en      in   push wr_data this cycle
//   wr_data    in   [7:0] byte to queue
//   clr_ovf    in   clear sticky overflow flag
//   full       out  FIFO holds DEPTH bytes
//   count      out  [ADDR_W:0] bytes queued (0..DEPTH)
//   overflow   out  sticky: a push was dropped
//   idle       out  FIFO empty and sequencer idle
//   TxD_busy   in   transmitter busy
//   TxD_start  out  one-cycle launch pulse (registered)
//   TxD_data   out  [7:0] byte being launched, held until the next load
module uart_tx_queue #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int BUSY_TO = 64
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              idle,
  input  logic              TxD_busy,
  output logic              TxD_start,
  output logic [7:0]        TxD_data
);

  localparam int TO_W = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [7:0]          r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overflow;
  logic                r_txd_start;
  logic [7:0]          r_txd_data;
  logic [TO_W-1:0]     r_to;

  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_timeout;

  // full comes from the registered count, so a pop in the same cycle
  // does not make room for a push arriving while full.
  assign w_full    = (r_count == (ADDR_W + 1)'(DEPTH));
  assign w_push    = wr_en && !w_full;
  assign w_drop    = wr_en && w_full;
  // LOAD is only entered with count != 0 and lasts one cycle; writes
  // never reduce count, so the head is always valid here.
  assign w_pop     = (r_state == ST_LOAD);
  assign w_timeout = (r_to == TO_W'(BUSY_TO - 1));

  // ---------------- FIFO storage (contents need no reset) ----------------
  always_ff @(posedge clk_50mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop takes priority over a coincident clear.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------- Launch sequencer ----------------
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (r_count != '0 && !TxD_busy) w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_START;
      ST_START:   w_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (TxD_busy)       w_next = ST_WAIT_LO;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_WAIT_LO: if (!TxD_busy) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // TxD_start is registered from the next-state decode so it is high
  // exactly while the state register holds START.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      r_txd_start <= 1'b0;
      r_txd_data  <= '0;
      r_to        <= '0;
    end else begin
      r_txd_start <= (w_next == ST_START);
      if (w_pop) begin
        r_txd_data <= r_mem[r_rd_ptr];
      end
      if (r_state == ST_START) begin
        r_to <= '0;
      end else if (r_state == ST_WAIT_HI) begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign idle      = (r_count == '0) && (r_state == ST_IDLE);
  assign TxD_start = r_txd_start;
  assign TxD_data  = r_txd_data;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Directed bench for uart_tx_queue with a small transmitter model that
//   raises TxD_busy one cycle after each start pulse and holds it 10 cycles.
module tb_uart_tx_queue;

  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int BUSY_TO = 64;

  logic              clk_50mhz = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              idle;
  logic              TxD_busy;
  logic              TxD_start;
  logic [7:0]        TxD_data;

  logic              force_busy;
  logic              model_en;
  logic              m_busy = 1'b0;
  int                m_cnt  = 0;

  int                n_pass  = 0;
  int                n_total = 0;
  int                cyc     = 0;
  int                pulse_cnt = 0;
  logic [7:0]        log_data [0:127];
  int                log_cyc  [0:127];

  uart_tx_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr_ovf   (clr_ovf),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .idle      (idle),
    .TxD_busy  (TxD_busy),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  assign TxD_busy = force_busy | m_busy;

  // Pulse logger and transmitter model. The model is not reset by rst so a
  // byte already handed over keeps transmitting.
  always @(posedge clk_50mhz) begin
    cyc <= cyc + 1;
    if (TxD_start) begin
      if (pulse_cnt < 128) begin
        log_data[pulse_cnt] <= TxD_data;
        log_cyc[pulse_cnt]  <= cyc;
      end
      pulse_cnt <= pulse_cnt + 1;
    end
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_busy <= 1'b0;
    end else if (TxD_start && model_en) begin
      m_busy <= 1'b1;
      m_cnt  <= 10;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk_50mhz);
    wr_en   = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    for (int i = 0; i < budget && pulse_cnt < target; i++) @(negedge clk_50mhz);
    check("pulse_wait", pulse_cnt, target);
  endtask

  int gap;

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    clr_ovf    = 1'b0;
    force_busy = 1'b0;
    model_en   = 1'b1;

    // 1. reset
    repeat (2) @(negedge clk_50mhz);
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_idle", idle, 1);
    check("rst_start", TxD_start, 0);
    check("rst_ovf", overflow, 0);
    check("rst_full", full, 0);
    check("rst_data", TxD_data, 8'h00);
    @(negedge clk_50mhz);

    // 2. single byte, latency
    push(8'h41);
    check("t2_count_n", count, 1);
    check("t2_start_n", TxD_start, 0);
    @(negedge clk_50mhz);
    check("t2_start_n1", TxD_start, 0);
    check("t2_count_n1", count, 1);
    @(negedge clk_50mhz);
    check("t2_start_n2", TxD_start, 1);
    check("t2_data_n2", TxD_data, 8'h41);
    check("t2_count_n2", count, 0);
    @(negedge clk_50mhz);
    check("t2_start_n3", TxD_start, 0);
    repeat (20) @(negedge clk_50mhz);
    check("t2_idle", idle, 1);
    check("t2_pulses", pulse_cnt, 1);
    check("t2_data_hold", TxD_data, 8'h41);

    // 3. fill while busy, then drain in order
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("t3_full", full, 1);
    check("t3_count", count, 16);
    repeat (5) @(negedge clk_50mhz);
    check("t3_no_start", pulse_cnt, 1);
    force_busy = 1'b0;
    wait_pulses(17, 600);
    for (int i = 0; i < 16; i++) check("t3_order", log_data[1 + i], 32'(i));
    repeat (20) @(negedge clk_50mhz);
    check("t3_idle", idle, 1);

    // 4. overflow on full, drop vs clear, drop with simultaneous pop
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    check("t4_full", full, 1);
    wr_en   = 1'b1;
    wr_data = 8'hBB;
    clr_ovf = 1'b1;
    @(negedge clk_50mhz);
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    check("t4_drop_wins", overflow, 1);
    check("t4_count16", count, 16);
    clr_ovf = 1'b1;
    @(negedge clk_50mhz);
    clr_ovf = 1'b0;
    check("t4_clr", overflow, 0);
    force_busy = 1'b0;
    @(negedge clk_50mhz);              // IDLE -> LOAD at this edge
    wr_en      = 1'b1;
    wr_data    = 8'hAA;
    force_busy = 1'b1;
    @(negedge clk_50mhz);              // pop and dropped push at this edge
    wr_en = 1'b0;
    check("t4_count15", count, 15);
    check("t4_ovf_set", overflow, 1);
    check("t4_notfull", full, 0);
    check("t4_start", TxD_start, 1);
    check("t4_head", TxD_data, 8'h10);
    clr_ovf = 1'b1;
    @(negedge clk_50mhz);
    clr_ovf = 1'b0;
    check("t4_clr2", overflow, 0);
    force_busy = 1'b0;
    wait_pulses(33, 600);
    for (int i = 0; i < 16; i++) check("t4_order", log_data[17 + i], 32'h10 + 32'(i));
    repeat (30) @(negedge clk_50mhz);
    check("t4_no_extra", pulse_cnt, 33);
    check("t4_idle", idle, 1);

    // 5. transmitter never goes busy: timeout recovers
    model_en = 1'b0;
    push(8'h55);
    push(8'h66);
    wait_pulses(35, 400);
    check("t5_data0", log_data[33], 8'h55);
    check("t5_data1", log_data[34], 8'h66);
    gap = log_cyc[34] - log_cyc[33];
    check("t5_gap_ok", 32'(gap >= BUSY_TO + 2 && gap <= BUSY_TO + 4), 1);
    repeat (BUSY_TO + 10) @(negedge clk_50mhz);
    check("t5_idle", idle, 1);
    check("t5_pulses", pulse_cnt, 35);

    // 6. reset while waiting for busy to fall with 5 bytes queued
    model_en = 1'b1;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    check("t6_count5", count, 5);
    check("t6_busy", TxD_busy, 1);
    check("t6_notidle", idle, 0);
    rst = 1'b1;
    @(negedge clk_50mhz);
    rst = 1'b0;
    check("t6_count0", count, 0);
    check("t6_idle", idle, 1);
    check("t6_start", TxD_start, 0);
    check("t6_data", TxD_data, 8'h00);
    check("t6_full", full, 0);
    repeat (40) @(negedge clk_50mhz);
    check("t6_no_more", pulse_cnt, 36);
    check("t6_idle_end", idle, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
